// File: rtl/reg_pair_loader_if.sv
// Serial-in / pair-out bundle for reg_pair_loader: serial bit handshake on one side,
// d1/d2 valid/ready holding stage on the other.
interface reg_pair_loader_if #(
   parameter int WIDTH = 8
);
   logic             s_bit;
   logic             s_valid;
   logic             s_ready;
   logic             s_abort;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport slave (
      input  s_bit, s_valid, s_abort, out_ready,
      output s_ready, d1, d2, out_valid, busy
   );

   modport master (
      output s_bit, s_valid, s_abort, out_ready,
      input  s_ready, d1, d2, out_valid, busy
   );
endinterface

// File: rtl/reg_pair_loader.sv
// Assembles an MSB-first bit stream into two WIDTH-bit words and presents them on
// d1/d2 through a one-entry holding stage; stalls the serial side while a frame waits.
module reg_pair_loader #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   reg_pair_loader_if.slave  bus
);
   localparam int FW = 2 * WIDTH;
   localparam int CW = $clog2(FW);
   localparam logic [CW-1:0] C_LAST   = CW'(FW - 1);
   localparam logic [CW-1:0] C_A_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      FILL_A    = 2'd0,
      FILL_B    = 2'd1,
      WAIT_XFER = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_count;
   logic [FW-1:0]    r_shift;
   logic [WIDTH-1:0] r_d1;
   logic [WIDTH-1:0] r_d2;
   logic             r_out_valid;

   state_t           w_state_next;
   logic [CW-1:0]    w_count_next;
   logic [FW-1:0]    w_shift_next;
   logic [WIDTH-1:0] w_d1_next;
   logic [WIDTH-1:0] w_d2_next;
   logic             w_out_valid_next;
   logic             w_hold_free;
   logic [FW-1:0]    w_frame;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= FILL_A;
         r_count     <= '0;
         r_shift     <= '0;
         r_d1        <= '0;
         r_d2        <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_count     <= w_count_next;
         r_shift     <= w_shift_next;
         r_d1        <= w_d1_next;
         r_d2        <= w_d2_next;
         r_out_valid <= w_out_valid_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_count_next     = r_count;
      w_shift_next     = r_shift;
      w_d1_next        = r_d1;
      w_d2_next        = r_d2;
      w_out_valid_next = r_out_valid;
      // Holding stage can take a pair this edge if empty or being drained now.
      w_hold_free      = !r_out_valid || bus.out_ready;
      w_frame          = {r_shift[FW-2:0], bus.s_bit};

      if (r_out_valid && bus.out_ready) begin
         w_out_valid_next = 1'b0;
      end

      case (r_state)
         FILL_A, FILL_B: begin
            if (bus.s_abort) begin
               w_count_next = '0;
               w_shift_next = '0;
               w_state_next = FILL_A;
            end else if (bus.s_valid) begin
               w_shift_next = w_frame;
               if (r_count == C_LAST) begin
                  w_count_next = '0;
                  if (w_hold_free) begin
                     w_d1_next        = w_frame[FW-1:WIDTH];
                     w_d2_next        = w_frame[WIDTH-1:0];
                     w_out_valid_next = 1'b1;
                     w_state_next     = FILL_A;
                  end else begin
                     w_state_next = WAIT_XFER;
                  end
               end else begin
                  w_count_next = r_count + CW'(1);
                  if (r_count == C_A_LAST) begin
                     w_state_next = FILL_B;
                  end
               end
            end
         end
         WAIT_XFER: begin
            if (w_hold_free) begin
               w_d1_next        = r_shift[FW-1:WIDTH];
               w_d2_next        = r_shift[WIDTH-1:0];
               w_out_valid_next = 1'b1;
               w_count_next     = '0;
               w_state_next     = FILL_A;
            end
         end
         default: begin
            w_state_next = FILL_A;
         end
      endcase
   end

   assign bus.s_ready   = (r_state != WAIT_XFER);
   assign bus.busy      = (r_count != '0) || (r_state == WAIT_XFER);
   assign bus.d1        = r_d1;
   assign bus.d2        = r_d2;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_reg_pair_loader.sv
// Bench for reg_pair_loader: directed frame table, hand-written stall/back-to-back/reset
// sequences, and random traffic checked every cycle against a queue-based model.
module tb_reg_pair_loader;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   reg_pair_loader_if #(.WIDTH(8)) bus ();

   reg_pair_loader #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: bits collected so far, an optional completed-but-stalled
   // frame, and the holding stage contents.
   logic       mq[$];
   logic       m_pend;
   logic [15:0] m_pval;
   logic [7:0] m_d1;
   logic [7:0] m_d2;
   logic       m_ov;

   function automatic void model_reset();
      mq.delete();
      m_pend = 1'b0;
      m_pval = '0;
      m_d1   = '0;
      m_d2   = '0;
      m_ov   = 1'b0;
   endfunction

   function automatic void model_step(input logic b, input logic v, input logic a,
                                      input logic r);
      logic        free;
      logic [15:0] val;
      free = !m_ov || r;
      if (m_ov && r) m_ov = 1'b0;
      if (m_pend) begin
         if (free) begin
            m_d1   = m_pval[15:8];
            m_d2   = m_pval[7:0];
            m_ov   = 1'b1;
            m_pend = 1'b0;
         end
      end else if (a) begin
         mq.delete();
      end else if (v) begin
         mq.push_back(b);
         if (mq.size() == 16) begin
            val = '0;
            for (int i = 0; i < 16; i++) val = {val[14:0], mq[i]};
            mq.delete();
            if (free) begin
               m_d1 = val[15:8];
               m_d2 = val[7:0];
               m_ov = 1'b1;
            end else begin
               m_pend = 1'b1;
               m_pval = val;
            end
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called just after a rising edge; checks outputs mid-cycle, then advances.
   task automatic cycle(input logic b, input logic v, input logic a, input logic r);
      bus.s_bit     = b;
      bus.s_valid   = v;
      bus.s_abort   = a;
      bus.out_ready = r;
      @(negedge clk);
      chk("s_ready", 16'(bus.s_ready), 16'(!m_pend));
      chk("busy", 16'(bus.busy), 16'((mq.size() != 0) || m_pend));
      chk("out_valid", 16'(bus.out_valid), 16'(m_ov));
      chk("d1", 16'(bus.d1), 16'(m_d1));
      chk("d2", 16'(bus.d2), 16'(m_d2));
      @(posedge clk);
      model_step(b, v, a, r);
      #1;
      bus.s_valid = 1'b0;
      bus.s_abort = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input int gap,
                             input logic ordy, input logic last_ordy);
      logic [15:0] fr;
      fr = {a, b};
      for (int i = 0; i < 16; i++) begin
         cycle(fr[15-i], 1'b1, 1'b0, (i == 15) ? last_ordy : ordy);
         if (i < 15) begin
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, ordy);
         end
      end
   endtask

   task automatic check_pair(input string nm, input logic [7:0] e1, input logic [7:0] e2);
      chk({nm, "_d1"}, 16'(bus.d1), 16'(e1));
      chk({nm, "_d2"}, 16'(bus.d2), 16'(e2));
      chk({nm, "_ov"}, 16'(bus.out_valid), 16'd1);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         gap;
      int         abort_after;
      logic [7:0] exp_d1;
      logic [7:0] exp_d2;
   } vec_t;

   vec_t vecs[5];

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{8'hBC, 8'h53, 0, 0,  8'hBC, 8'h53};
      vecs[1] = '{8'hA5, 8'h5A, 3, 0,  8'hA5, 8'h5A};
      vecs[2] = '{8'h0F, 8'hF0, 0, 5,  8'h0F, 8'hF0};
      vecs[3] = '{8'h00, 8'h80, 1, 12, 8'h00, 8'h80};
      vecs[4] = '{8'hFF, 8'h01, 2, 0,  8'hFF, 8'h01};

      bus.s_bit = 1'b0; bus.s_valid = 1'b0; bus.s_abort = 1'b0; bus.out_ready = 1'b0;
      rst = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 16'(bus.s_ready), 16'd1);
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_ov", 16'(bus.out_valid), 16'd0);
      chk("rst_d1", 16'(bus.d1), 16'd0);
      chk("rst_d2", 16'(bus.d2), 16'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven frames, drained continuously.
      foreach (vecs[k]) begin
         for (int i = 0; i < vecs[k].abort_after; i++)
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
         if (vecs[k].abort_after > 0) cycle(1'b1, 1'b1, 1'b1, 1'b1);
         send_frame(vecs[k].a, vecs[k].b, vecs[k].gap, 1'b1, 1'b1);
         check_pair("vec", vecs[k].exp_d1, vecs[k].exp_d2);
         chk("vec_s_ready", 16'(bus.s_ready), 16'd1);
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         chk("vec_one_cycle", 16'(bus.out_valid), 16'd0);
      end

      // Stalled consumer: second frame waits in the shift register.
      send_frame(8'hBC, 8'h00, 0, 1'b0, 1'b0);
      send_frame(8'h53, 8'hFF, 0, 1'b0, 1'b0);
      check_pair("stall_hold", 8'hBC, 8'h00);
      chk("stall_s_ready", 16'(bus.s_ready), 16'd0);
      chk("stall_busy", 16'(bus.busy), 16'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check_pair("stall_xfer", 8'h53, 8'hFF);
      chk("stall_s_ready_after", 16'(bus.s_ready), 16'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back: drain on the same edge as the final bit of the next frame.
      send_frame(8'h11, 8'h22, 0, 1'b0, 1'b0);
      send_frame(8'h33, 8'h44, 0, 1'b0, 1'b1);
      check_pair("b2b", 8'h33, 8'h44);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-cycle with a pair held and a frame in flight.
      send_frame(8'hC3, 8'h3C, 0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_d1", 16'(bus.d1), 16'd0);
      chk("arst_d2", 16'(bus.d2), 16'd0);
      chk("arst_ov", 16'(bus.out_valid), 16'd0);
      chk("arst_busy", 16'(bus.busy), 16'd0);
      chk("arst_s_ready", 16'(bus.s_ready), 16'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send_frame(8'h81, 8'h7E, 0, 1'b1, 1'b1);
      check_pair("arst_after", 8'h81, 8'h7E);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_pair_loader.md
Name: reg_pair_loader

Overview:
Serial-to-parallel front end that feeds the dual 8-bit register set (d1/d2 inputs).
- Shifts in a bit stream MSB-first and assembles two WIDTH-bit words (word A, then word B).
- Presents the pair on d1/d2 from a holding stage with a valid/ready handshake.
- Stalls the serial side with s_ready when the holding stage cannot accept a new pair.

Parameters:
WIDTH, 8, width of each assembled word (d1 and d2).

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
s_bit  input  1  serial data bit.
s_valid  input  1  s_bit is valid this cycle.
s_ready  output  1  loader accepts s_bit this cycle.
s_abort  input  1  discard the partially assembled frame.
d1  output  WIDTH  word A of the current pair (first WIDTH bits received).
d2  output  WIDTH  word B of the current pair (next WIDTH bits).
out_valid  output  1  d1/d2 hold a pair not yet consumed.
out_ready  input  1  consumer takes the pair this cycle.
busy  output  1  frame partially assembled (bit count nonzero) or stalled in WAIT_XFER.

Behaviour:
- Reset (rst=0, asynchronous): state=FILL_A, bit count=0, shift register=0, d1=0, d2=0, out_valid=0. s_ready=1 and busy=0 once reset is applied. Any frame in progress at reset assertion is lost.
- Accept: a bit is taken on a rising edge where s_valid=1 and s_ready=1. Internal shift register is 2*WIDTH bits wide and shifts left with s_bit entering at the LSB.
- Bit counter: 0..2*WIDTH-1, increments per accepted bit and wraps to 0 on the last bit.
- Word mapping, MSB-first: the 1st bit received lands in d1[WIDTH-1]; the (2*WIDTH)th bit lands in d2[0].
- FSM states:
  - FILL_A: count < WIDTH. Move to FILL_B when the WIDTH-th bit is accepted.
  - FILL_B: count >= WIDTH. When the last bit is accepted:
    - If the holding stage is free this cycle (out_valid=0, or out_valid=1 and out_ready=1): load d1/d2 with the full frame including that bit, set out_valid=1, return to FILL_A.
    - Otherwise go to WAIT_XFER with the complete frame held in the shift register.
  - WAIT_XFER: s_ready=0. On the first edge where out_valid=0, or out_valid=1 and out_ready=1: load d1/d2 from the shift register, out_valid=1, count=0, go to FILL_A.
- s_ready = 1 in FILL_A/FILL_B, 0 in WAIT_XFER. It is combinational from state only and does not depend on s_valid.
- Handshake: out_valid stays high, with d1/d2 stable, until an edge with out_ready=1.
  - Drain without a simultaneous load: out_valid falls next cycle.
  - Drain and load on the same edge: out_valid stays 1 and d1/d2 take the new pair (back-to-back, no bubble).
- Latency: out_valid rises on the same edge that accepts the final bit when the holding stage is free. With continuous s_valid, one pair is produced every 2*WIDTH cycles.
- s_abort (synchronous, sampled on the edge):
  - In FILL_A/FILL_B: count=0, shift register=0, state=FILL_A. A bit offered on the same edge is discarded.
  - In WAIT_XFER: ignored, because the frame is complete.
  - Never affects d1/d2/out_valid.
- s_valid=0 cycles: hold all state. Gaps between bits are allowed anywhere in a frame.
- out_ready while out_valid=0: no effect.
- busy = (count != 0) or (state == WAIT_XFER).

Test Plan:
- Reset, then 16 continuous bits 1011_1100_0101_0011 with out_ready=1 -> d1=8'hBC, d2=8'h53, out_valid=1 for exactly one cycle after the edge taking bit 16; s_ready stays 1.
- out_ready=0: send pair 8'hBC/8'h00, then a second pair 8'h53/8'hFF -> first pair held stable; after bit 32, s_ready=0 and busy=1. Raise out_ready for one cycle -> d1=8'h53, d2=8'hFF, out_valid still 1, s_ready=1 next cycle.
- Back-to-back: out_ready=1 pulsed on the same edge as the final bit of frame 2 -> no out_valid bubble; d1/d2 switch directly to frame 2.
- Insert s_valid=0 gaps of 3 cycles between bits of 8'hA5/8'h5A -> same result as the gap-free case; busy=1 throughout the gaps.
- s_abort after 5 bits, then a full 8'h0F/8'hF0 frame -> d1=8'h0F, d2=8'hF0, with no leftover bits from the aborted frame.
- Drive rst=0 mid-cycle (not on a clk edge) after 10 bits with out_valid=1 -> d1=0, d2=0, out_valid=0, busy=0 immediately; after release, a new frame 8'h81/8'h7E decodes correctly.
